prio_encoder_queue: RTL and testbench

- Parametrised, registered successor to the team's combinational 4-to-2 encoder.
- Captures single-cycle request pulses on N lines into a pending register and emits one encoded index per grant.
- Output uses a valid/ready handshake, so a downstream consumer drains requests one at a time, losslessly.
- Selection order is fixed-priority or round-robin. Used wherever multiple event sources share one index-encoded channel (interrupt/event aggregation).

---
 rtl/prio_encoder_queue.sv | 141 ++++++++++++++
 tb/tb_prio_encoder_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_queue.sv
// Purpose: queues single-cycle request pulses on N lines and emits one encoded index per grant.
// Latency: 1 cycle from req to out_valid when the output slot is free and no competitor wins.
// Backpressure: out_valid/out_ready; while stalled the output holds and new requests merge into pending.
module prio_encoder_queue #(
  parameter int N       = 8,
  parameter int IDX_W   = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending,
  output logic             busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;

  logic [N-1:0]     cand;
  logic             cand_any;
  logic             slot_free;
  logic             grant;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;

  // Highest set index wins; later (higher) matches overwrite earlier ones.
  function automatic logic [IDX_W-1:0] hi_pick(input logic [N-1:0] c);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i]) w = IDX_W'(i);
    end
    return w;
  endfunction

  // Round-robin: first set index at offsets 1..N above last, wrapping.
  // Scanning offsets from far to near lets the nearest match overwrite.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] c,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] w;
    int               pos;
    w = '0;
    for (int o = N - 1; o >= 0; o--) begin
      pos = int'(last) + 1 + o;
      if (pos >= N) pos = pos - N;
      if (c[pos]) w = IDX_W'(pos);
    end
    return w;
  endfunction

  // Decode compares against every legal index so a stray code never indexes past N-1.
  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) == idx) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Candidate set, slot availability and the winner for this cycle.
  always_comb begin
    cand      = pending | req;
    cand_any  = |cand;
    slot_free = (state == EMPTY) || out_ready;
    grant     = slot_free && cand_any;
    if (RR_MODE != 0) begin
      win_idx = rr_pick(cand, last_idx);
    end else begin
      win_idx = hi_pick(cand);
    end
    win_onehot = to_onehot(win_idx);
  end

  // Output slot state machine, pending queue and round-robin pointer.
  // A granted line is cleared from pending even if req re-asserts it this
  // cycle, so the grant consumes that request rather than leaving a copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_idx    <= '0;
      out_onehot <= '0;
      pending    <= '0;
      last_idx   <= IDX_W'(N - 1);
    end else begin
      pending <= cand & ~(grant ? win_onehot : {N{1'b0}});
      if (grant) begin
        last_idx <= win_idx;
      end
      case (state)
        EMPTY: begin
          if (cand_any) begin
            state      <= FULL;
            out_idx    <= win_idx;
            out_onehot <= win_onehot;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (cand_any) begin
              out_idx    <= win_idx;
              out_onehot <= win_onehot;
            end else begin
              state      <= EMPTY;
              out_idx    <= '0;
              out_onehot <= '0;
            end
          end
        end
        default: begin
          state      <= EMPTY;
          out_idx    <= '0;
          out_onehot <= '0;
        end
      endcase
    end
  end

  assign out_valid = (state == FULL);
  assign busy      = (|pending) || out_valid;

  // Structural invariants of the output slot.
  a_onehot_idle : assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_onehot == '0));
  a_onehot_match : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_onehot == to_onehot(out_idx)));
  a_idx_range : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (int'(out_idx) < N));
  a_hold_stall : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_idx) && $stable(out_onehot)));

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Bench for prio_encoder_queue: fixed-priority N=8, round-robin N=8, round-robin N=5.
// Directed table plus hand sequences, then random traffic against a queue-level model.
// All three instances share req/out_ready so the model checks run in every phase.
module tb_prio_encoder_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;

  logic       fp_vld, rr_vld, n5_vld;
  logic [2:0] fp_idx, rr_idx, n5_idx;
  logic [7:0] fp_oh, rr_oh, fp_pend, rr_pend;
  logic [4:0] n5_oh, n5_pend;
  logic       fp_busy, rr_busy, n5_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prio_encoder_queue #(.N(8), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req(req), .out_valid(fp_vld), .out_ready(out_ready),
    .out_idx(fp_idx), .out_onehot(fp_oh), .pending(fp_pend), .busy(fp_busy));

  prio_encoder_queue #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .out_valid(rr_vld), .out_ready(out_ready),
    .out_idx(rr_idx), .out_onehot(rr_oh), .pending(rr_pend), .busy(rr_busy));

  prio_encoder_queue #(.N(5), .RR_MODE(1)) u_n5 (
    .clk(clk), .rst(rst), .req(req[4:0]), .out_valid(n5_vld), .out_ready(out_ready),
    .out_idx(n5_idx), .out_onehot(n5_oh), .pending(n5_pend), .busy(n5_busy));

  // Reference model: a set of waiting lines plus the one item sitting in the output slot.
  typedef struct {
    bit [63:0] pend;
    bit        vld;
    int        idx;
    int        last;
  } model_t;

  model_t m_fp, m_rr, m_n5;

  function automatic model_t m_reset(int n);
    model_t s;
    s.pend = '0;
    s.vld  = 1'b0;
    s.idx  = 0;
    s.last = n - 1;
    return s;
  endfunction

  function automatic model_t m_step(model_t s, int n, bit rr, bit [63:0] r, bit rdy);
    model_t    t;
    bit [63:0] mask;
    bit [63:0] c;
    int        w;
    t    = s;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    c    = (s.pend | r) & mask;
    w    = -1;
    if (!s.vld || rdy) begin
      if (c != 0) begin
        if (!rr) begin
          for (int i = n - 1; i >= 0; i--) begin
            if (c[i]) begin w = i; break; end
          end
        end else begin
          for (int k = 1; k <= n; k++) begin
            int p;
            p = (s.last + k) % n;
            if (c[p]) begin w = p; break; end
          end
        end
        c[w]   = 1'b0;
        t.vld  = 1'b1;
        t.idx  = w;
        t.last = w;
      end else begin
        t.vld = 1'b0;
      end
    end
    t.pend = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input model_t m, input logic vld,
                           input logic [63:0] idx, input logic [63:0] oh,
                           input logic [63:0] pend, input logic bsy);
    chk({tag, ".valid"}, 64'(vld), 64'(m.vld));
    if (m.vld) chk({tag, ".idx"}, idx, 64'(m.idx));
    chk({tag, ".onehot"}, oh, m.vld ? (64'd1 << m.idx) : 64'd0);
    chk({tag, ".pending"}, pend, m.pend);
    chk({tag, ".busy"}, 64'(bsy), 64'((m.pend != 0) || m.vld));
  endtask

  task automatic check_all();
    check_dut("fp", m_fp, fp_vld, 64'(fp_idx), 64'(fp_oh), 64'(fp_pend), fp_busy);
    check_dut("rr", m_rr, rr_vld, 64'(rr_idx), 64'(rr_oh), 64'(rr_pend), rr_busy);
    check_dut("n5", m_n5, n5_vld, 64'(n5_idx), 64'(n5_oh), 64'(n5_pend), n5_busy);
  endtask

  // Entered at posedge+1; applies inputs, crosses one edge, compares at posedge+1.
  task automatic cycle(input logic [7:0] r, input logic rd);
    req       = r;
    out_ready = rd;
    @(posedge clk);
    m_fp = m_step(m_fp, 8, 1'b0, 64'(r), rd);
    m_rr = m_step(m_rr, 8, 1'b1, 64'(r), rd);
    m_n5 = m_step(m_n5, 5, 1'b1, 64'(r), 64'(r) == 0 ? 1'b0 | rd : rd);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges; checked before any edge arrives.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_fp = m_reset(8);
    m_rr = m_reset(8);
    m_n5 = m_reset(5);
    check_all();
    chk("rst.fp_pending", 64'(fp_pend), 64'h0);
    chk("rst.fp_busy", 64'(fp_busy), 64'h0);
    req       = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       v;
    int         idx;
    logic [7:0] oh;
    logic [7:0] pend;
  } vec_t;

  function automatic vec_t mk(logic [7:0] r, logic rd, logic v, int idx,
                              logic [7:0] oh, logic [7:0] pend);
    vec_t x;
    x.req  = r;
    x.rdy  = rd;
    x.v    = v;
    x.idx  = idx;
    x.oh   = oh;
    x.pend = pend;
    return x;
  endfunction

  vec_t tbl[22];

  initial begin
    // Directed vectors for the fixed-priority instance, starting from reset.
    tbl[0]  = mk(8'h08, 1, 1, 3, 8'h08, 8'h00);  // single request, 1-cycle latency
    tbl[1]  = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);
    tbl[2]  = mk(8'h86, 1, 1, 7, 8'h80, 8'h06);  // burst: 7, 2, 1
    tbl[3]  = mk(8'h00, 1, 1, 2, 8'h04, 8'h02);
    tbl[4]  = mk(8'h00, 1, 1, 1, 8'h02, 8'h00);
    tbl[5]  = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);
    tbl[6]  = mk(8'h01, 0, 1, 0, 8'h01, 8'h00);  // backpressure: 0 held, 5 queued
    tbl[7]  = mk(8'h20, 0, 1, 0, 8'h01, 8'h20);
    tbl[8]  = mk(8'h00, 0, 1, 0, 8'h01, 8'h20);
    tbl[9]  = mk(8'h00, 1, 1, 5, 8'h20, 8'h00);
    tbl[10] = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);
    tbl[11] = mk(8'h10, 0, 1, 4, 8'h10, 8'h00);  // same-line collision while held
    tbl[12] = mk(8'h10, 0, 1, 4, 8'h10, 8'h10);
    tbl[13] = mk(8'h10, 1, 1, 4, 8'h10, 8'h00);  // re-grant of 4 consumes the new pulse too
    tbl[14] = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);
    tbl[15] = mk(8'h04, 1, 1, 2, 8'h04, 8'h00);  // request granted on arrival, no copy kept
    tbl[16] = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);
    tbl[17] = mk(8'h01, 0, 1, 0, 8'h01, 8'h00);  // pending vs fresh request priority
    tbl[18] = mk(8'h02, 0, 1, 0, 8'h01, 8'h02);
    tbl[19] = mk(8'h40, 1, 1, 6, 8'h40, 8'h02);
    tbl[20] = mk(8'h00, 1, 1, 1, 8'h02, 8'h00);
    tbl[21] = mk(8'h00, 1, 0, 0, 8'h00, 8'h00);

    // Power-on reset
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    m_fp = m_reset(8);
    m_rr = m_reset(8);
    m_n5 = m_reset(5);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Table phase
    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].req, tbl[i].rdy);
      chk($sformatf("tbl[%0d].valid", i), 64'(fp_vld), 64'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("tbl[%0d].idx", i), 64'(fp_idx), 64'(tbl[i].idx));
      chk($sformatf("tbl[%0d].onehot", i), 64'(fp_oh), 64'(tbl[i].oh));
      chk($sformatf("tbl[%0d].pending", i), 64'(fp_pend), 64'(tbl[i].pend));
      chk($sformatf("tbl[%0d].busy", i), 64'(fp_busy), 64'((tbl[i].pend != 0) || tbl[i].v));
    end

    // Reset mid-burst with pending = 8'hA5
    cycle(8'h01, 1'b0);
    cycle(8'hA5, 1'b0);
    chk("a5.fp_pending", 64'(fp_pend), 64'hA5);
    do_reset();
    chk("a5.after_rst_valid", 64'(fp_vld), 64'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(8'h00, 1'b1);
      chk($sformatf("idle[%0d].valid", i), 64'(fp_vld), 64'h0);
    end

    // Round-robin fairness with all lines held high
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle(8'hFF, 1'b1);
      chk($sformatf("rr8[%0d].idx", k), 64'(rr_idx), 64'(k % 8));
      chk($sformatf("rr5[%0d].idx", k), 64'(n5_idx), 64'(k % 5));
      chk($sformatf("fp_hold[%0d].idx", k), 64'(fp_idx), 64'h7);
    end
    for (int k = 0; k < 12; k++) cycle(8'h00, 1'b1);

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        logic [7:0] r;
        logic       rd;
        case ($urandom_range(0, 2))
          0:       r = 8'($urandom);
          1:       r = 8'($urandom & $urandom & $urandom);
          default: r = 8'h00;
        endcase
        rd = ($urandom_range(0, 3) != 0);
        cycle(r, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
